// File: rtl/median_pivot_select.sv
// Iterative median search controller: chooses a pivot for each partition pass, narrows the
// window toward the lower-median rank k, and reports the median through a valid/ready handshake.
module median_pivot_select #(
    parameter int         BUFF_SIZE     = 32,
    parameter int         BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
    parameter logic [7:0] INIT_PIVOT    = 8'd128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [BUFF_SIZE_BIT-1:0] init_size,
    input  logic                     fill_done,
    input  logic [BUFF_SIZE_BIT-1:0] lower_size,
    input  logic [BUFF_SIZE_BIT-1:0] equal_size,
    input  logic [BUFF_SIZE_BIT-1:0] larger_size,
    input  logic [7:0]               min_lower,
    input  logic [7:0]               max_lower,
    input  logic [7:0]               min_larger,
    input  logic [7:0]               max_larger,
    output logic [7:0]               pivot,
    output logic [BUFF_SIZE_BIT-1:0] buff_size,
    output logic                     send_req,
    output logic                     keep_lower,
    output logic                     keep_larger,
    output logic                     busy,
    output logic [7:0]               median,
    output logic                     median_valid,
    input  logic                     median_ready,
    output logic                     err,
    output logic [3:0]               iter_count
);

    localparam int W = BUFF_SIZE_BIT;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FILL,
        DECIDE,
        SEND,
        DONE
    } state_t;

    state_t state, next_state;

    logic [W-1:0] k;
    logic         keep_sel_lower;
    logic         keep_sel_larger;

    logic [W:0]   le;
    logic [W+1:0] total;
    logic         size_mismatch;
    logic         k_in_lower;
    logic         k_in_larger;
    logic         lower_single;
    logic         larger_single;
    logic         start_ok;
    logic [7:0]   mid_lower;
    logic [7:0]   mid_larger;

    assign le            = {1'b0, lower_size} + {1'b0, equal_size};
    assign total         = {2'b00, lower_size} + {2'b00, equal_size} + {2'b00, larger_size};
    assign size_mismatch = (total != {2'b00, buff_size});
    assign k_in_lower    = (k < lower_size);
    assign k_in_larger   = ({1'b0, k} >= le);
    assign lower_single  = (min_lower == max_lower);
    assign larger_single = (min_larger == max_larger);
    assign start_ok      = start && (init_size != '0);
    // Midpoint of the kept partition's extrema; the 9-bit sum avoids overflow.
    assign mid_lower     = 8'((9'(min_lower) + 9'(max_lower)) >> 1);
    assign mid_larger    = 8'((9'(min_larger) + 9'(max_larger)) >> 1);

    assign busy         = (state != IDLE);
    assign send_req     = (state == SEND);
    assign median_valid = (state == DONE);
    assign keep_lower   = (state == SEND) && keep_sel_lower;
    assign keep_larger  = (state == SEND) && keep_sel_larger;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start_ok) next_state = WAIT_FILL;
            WAIT_FILL: if (fill_done) next_state = DECIDE;
            DECIDE: begin
                if (size_mismatch) begin
                    next_state = IDLE;
                end else if (k_in_lower) begin
                    next_state = lower_single ? DONE : SEND;
                end else if (!k_in_larger) begin
                    next_state = DONE;
                end else begin
                    next_state = larger_single ? DONE : SEND;
                end
            end
            SEND:      if (!fill_done) next_state = WAIT_FILL;
            DONE:      if (median_ready) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Window context; partition results are only consumed while in DECIDE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pivot           <= INIT_PIVOT;
            buff_size       <= '0;
            k               <= '0;
            median          <= '0;
            iter_count      <= '0;
            keep_sel_lower  <= 1'b0;
            keep_sel_larger <= 1'b0;
            err             <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        pivot      <= INIT_PIVOT;
                        buff_size  <= init_size;
                        k          <= (init_size - W'(1)) >> 1;
                        iter_count <= '0;
                    end
                end
                DECIDE: begin
                    iter_count      <= (iter_count == 4'd15) ? 4'd15 : iter_count + 4'd1;
                    keep_sel_lower  <= 1'b0;
                    keep_sel_larger <= 1'b0;
                    if (size_mismatch) begin
                        err <= 1'b1;
                    end else if (k_in_lower) begin
                        buff_size      <= lower_size;
                        keep_sel_lower <= 1'b1;
                        if (lower_single) begin
                            median <= min_lower;
                        end else begin
                            pivot <= mid_lower;
                        end
                    end else if (!k_in_larger) begin
                        median <= pivot;
                    end else begin
                        k               <= W'({1'b0, k} - le);
                        buff_size       <= larger_size;
                        keep_sel_larger <= 1'b1;
                        if (larger_single) begin
                            median <= min_larger;
                        end else begin
                            pivot <= mid_larger;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_median_pivot_select.sv
// Bench for median_pivot_select: plays the fill stage from a queue-based partition model and
// checks every pass plus the final median against a sorted-window reference.
module tb_median_pivot_select;

    localparam int BS  = 32;
    localparam int BSB = $clog2(BS) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [BSB-1:0] init_size;
    logic           fill_done;
    logic [BSB-1:0] lower_size, equal_size, larger_size;
    logic [7:0]     min_lower, max_lower, min_larger, max_larger;
    logic [7:0]     pivot;
    logic [BSB-1:0] buff_size;
    logic           send_req, keep_lower, keep_larger, busy;
    logic [7:0]     median;
    logic           median_valid, median_ready, err;
    logic [3:0]     iter_count;

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [7:0] window_q[$];

    median_pivot_select #(.BUFF_SIZE(BS), .BUFF_SIZE_BIT(BSB), .INIT_PIVOT(8'd128)) dut (
        .clk(clk), .rst(rst), .start(start), .init_size(init_size), .fill_done(fill_done),
        .lower_size(lower_size), .equal_size(equal_size), .larger_size(larger_size),
        .min_lower(min_lower), .max_lower(max_lower), .min_larger(min_larger),
        .max_larger(max_larger), .pivot(pivot), .buff_size(buff_size), .send_req(send_req),
        .keep_lower(keep_lower), .keep_larger(keep_larger), .busy(busy), .median(median),
        .median_valid(median_valid), .median_ready(median_ready), .err(err),
        .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        if (observed !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Runs one window held in window_q; hold = cycles median_ready stays low in DONE.
    task automatic applyStimulus(input int hold);
        logic [7:0] cur[$];
        logic [7:0] srt[$];
        logic [7:0] lo_q[$], eq_q[$], hi_q[$];
        logic [7:0] piv, exp_med, ref_med, mnl, mxl, mnh, mxh;
        int n, k, le, iters;
        bit finished, sel_lower;

        cur = window_q;
        srt = window_q;
        srt.sort();
        n = cur.size();
        k = (n - 1) >> 1;
        ref_med = srt[k];
        piv = 8'd128;
        iters = 0;
        finished = 0;
        exp_med = 8'd0;

        @(negedge clk);
        start = 1'b1;
        init_size = BSB'(n);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 1);
        checkOutput("pivot_initial", 32'(pivot), 128);
        checkOutput("buff_size_initial", 32'(buff_size), n);
        checkOutput("iter_initial", 32'(iter_count), 0);

        for (int pass = 0; pass < 20 && !finished; pass++) begin
            lo_q.delete(); eq_q.delete(); hi_q.delete();
            foreach (cur[i]) begin
                if (cur[i] < piv) lo_q.push_back(cur[i]);
                else if (cur[i] == piv) eq_q.push_back(cur[i]);
                else hi_q.push_back(cur[i]);
            end
            mnl = 8'd0; mxl = 8'd0; mnh = 8'd0; mxh = 8'd0;
            if (lo_q.size() > 0) begin
                mnl = lo_q.min()[0];
                mxl = lo_q.max()[0];
            end
            if (hi_q.size() > 0) begin
                mnh = hi_q.min()[0];
                mxh = hi_q.max()[0];
            end
            iters = (iters < 15) ? iters + 1 : 15;

            lower_size = BSB'(lo_q.size());
            equal_size = BSB'(eq_q.size());
            larger_size = BSB'(hi_q.size());
            min_lower = mnl; max_lower = mxl; min_larger = mnh; max_larger = mxh;
            fill_done = 1'b1;
            @(negedge clk);
            fill_done = 1'b0;
            @(negedge clk);

            le = lo_q.size() + eq_q.size();
            sel_lower = 0;
            if (k < lo_q.size()) begin
                sel_lower = 1;
                if (mnl == mxl) begin exp_med = mnl; finished = 1; end
                else begin piv = 8'((int'(mnl) + int'(mxl)) / 2); cur = lo_q; end
            end else if (k < le) begin
                exp_med = piv;
                finished = 1;
            end else begin
                k = k - le;
                if (mnh == mxh) begin exp_med = mnh; finished = 1; end
                else begin piv = 8'((int'(mnh) + int'(mxh)) / 2); cur = hi_q; end
            end

            checkOutput("iter_count", 32'(iter_count), iters);
            if (finished) begin
                checkOutput("median_valid", 32'(median_valid), 1);
                checkOutput("median_model", 32'(median), exp_med);
                checkOutput("median_sorted", 32'(median), ref_med);
                checkOutput("send_req_done", 32'(send_req), 0);
                checkOutput("keep_done", {30'd0, keep_lower, keep_larger}, 0);
            end else begin
                checkOutput("send_req", 32'(send_req), 1);
                checkOutput("keep_flags", {30'd0, keep_lower, keep_larger}, sel_lower ? 2 : 1);
                checkOutput("pivot_next", 32'(pivot), piv);
                checkOutput("buff_size_next", 32'(buff_size), cur.size());
                checkOutput("median_valid_send", 32'(median_valid), 0);
                @(negedge clk);
                checkOutput("send_exit", 32'(send_req), 0);
                checkOutput("keep_clear", {30'd0, keep_lower, keep_larger}, 0);
            end
        end
        if (!finished) checkOutput("converge", 0, 1);

        median_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(median_valid), 1);
            checkOutput("hold_median", 32'(median), ref_med);
        end
        median_ready = 1'b1;
        start = 1'b1;
        init_size = BSB'(5);
        @(negedge clk);
        median_ready = 1'b0;
        start = 1'b0;
        checkOutput("release_valid", 32'(median_valid), 0);
        checkOutput("release_busy", 32'(busy), 0);
        @(negedge clk);
        checkOutput("start_ignored_in_done", 32'(busy), 0);
    endtask

    initial begin
        int n, mode;
        logic [7:0] base;

        rst = 1'b1;
        start = 1'b0; init_size = '0; fill_done = 1'b0; median_ready = 1'b0;
        lower_size = '0; equal_size = '0; larger_size = '0;
        min_lower = '0; max_lower = '0; min_larger = '0; max_larger = '0;
        #1;
        checkOutput("rst_pivot", 32'(pivot), 128);
        checkOutput("rst_buff_size", 32'(buff_size), 0);
        checkOutput("rst_median", 32'(median), 0);
        checkOutput("rst_iter", 32'(iter_count), 0);
        checkOutput("rst_flags", {26'd0, busy, send_req, keep_lower, keep_larger, median_valid, err}, 0);
        @(negedge clk);
        rst = 1'b0;

        // zero-size start is ignored
        @(negedge clk);
        start = 1'b1; init_size = '0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("zero_size_ignored", 32'(busy), 0);

        $display("[TB] directed windows");
        window_q = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        applyStimulus(0);
        window_q = '{8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77};
        applyStimulus(0);
        window_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        applyStimulus(5);

        $display("[TB] size mismatch");
        @(negedge clk);
        start = 1'b1; init_size = BSB'(9);
        @(negedge clk);
        start = 1'b0;
        lower_size = BSB'(3); equal_size = BSB'(1); larger_size = BSB'(3);
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        @(negedge clk);
        checkOutput("err_pulse", 32'(err), 1);
        checkOutput("err_idle", 32'(busy), 0);
        checkOutput("err_no_valid", 32'(median_valid), 0);
        @(negedge clk);
        checkOutput("err_one_cycle", 32'(err), 0);

        $display("[TB] reset during SEND");
        @(negedge clk);
        start = 1'b1; init_size = BSB'(9);
        @(negedge clk);
        start = 1'b0;
        lower_size = BSB'(9); equal_size = '0; larger_size = '0;
        min_lower = 8'd10; max_lower = 8'd90; min_larger = '0; max_larger = '0;
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_send", 32'(send_req), 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_send_req", 32'(send_req), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_keep", {30'd0, keep_lower, keep_larger}, 0);
        checkOutput("rst_pivot_mid", 32'(pivot), 128);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_no_valid", 32'(median_valid), 0);
        window_q = '{8'd200, 8'd3, 8'd99, 8'd150, 8'd7};
        applyStimulus(1);

        $display("[TB] random windows");
        for (int w = 0; w < 40; w++) begin
            window_q.delete();
            n = $urandom_range(1, BS);
            mode = $urandom_range(0, 2);
            base = 8'($urandom_range(0, 250));
            for (int i = 0; i < n; i++) begin
                if (mode == 0) window_q.push_back(8'($urandom_range(0, 255)));
                else if (mode == 1) window_q.push_back(base + 8'($urandom_range(0, 5)));
                else window_q.push_back(base);
            end
            applyStimulus($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/median_pivot_select.md
MEDIAN_PIVOT_SELECT -- requirements
Module: median_pivot_select

Interface
REQ-001 SHALL have parameter BUFF_SIZE, default 32; maximum window size in pixels.
REQ-002 SHALL have parameter BUFF_SIZE_BIT, default $clog2(BUFF_SIZE)+1; width of all size and position fields.
REQ-003 SHALL have parameter INIT_PIVOT, default 8'd128; pivot used for the first pass of every window.
REQ-004 SHALL have a single clock domain and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1; rising-edge clock.
REQ-006 SHALL have port rst, input, 1; asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1; begin a new window, sampled in IDLE only.
REQ-008 SHALL have port init_size, input, BUFF_SIZE_BIT; window pixel count, sampled with start.
REQ-009 SHALL have port fill_done, input, 1; current partition pass complete, driven by the fill stage.
REQ-010 SHALL have ports lower_size, equal_size and larger_size, input, BUFF_SIZE_BIT each; partition counts.
REQ-011 SHALL have ports min_lower, max_lower, min_larger and max_larger, input, 8 each; partition extrema.
REQ-012 SHALL have port pivot, output, 8; pivot for the current pass.
REQ-013 SHALL have port buff_size, output, BUFF_SIZE_BIT; expected pixel count of the current pass.
REQ-014 SHALL have port send_req, output, 1; request to restart fill counters and recirculate the kept partition.
REQ-015 SHALL have ports keep_lower and keep_larger, output, 1 each; partition to recirculate, valid while send_req is high.
REQ-016 SHALL have port busy, output, 1; high in every state except IDLE.
REQ-017 SHALL have ports median (output, 8), median_valid (output, 1) and median_ready (input, 1); result handshake.
REQ-018 SHALL have port err, output, 1; partition-count mismatch, one-cycle pulse.
REQ-019 SHALL have port iter_count, output, 4; passes completed in the current window, saturating at 15.

Function
REQ-020 SHALL use FSM states IDLE, WAIT_FILL, DECIDE, SEND and DONE.
REQ-021 IDLE SHALL behave as follows: on start with init_size != 0, load pivot=INIT_PIVOT, buff_size=init_size, k=(init_size-1)>>1 (lower median), iter_count=0, then go to WAIT_FILL; start with init_size==0 SHALL be ignored.
REQ-022 WAIT_FILL SHALL go to DECIDE on fill_done=1; start SHALL be ignored.
REQ-023 DECIDE SHALL compute le=lower_size+equal_size at BUFF_SIZE_BIT+1 width and increment iter_count (saturating); it lasts one cycle.
REQ-024 DECIDE SHALL, if lower_size+equal_size+larger_size != buff_size, pulse err and go to IDLE.
REQ-025 DECIDE SHALL, if k < lower_size, keep lower with buff_size=lower_size; then, if min_lower==max_lower, set median=min_lower and go to DONE; otherwise set pivot=(min_lower+max_lower)>>1 (9-bit sum) and go to SEND.
REQ-026 DECIDE SHALL, if lower_size <= k < le, set median=pivot and go to DONE.
REQ-027 DECIDE SHALL, if k >= le, keep larger with k=k-le and buff_size=larger_size; then, if min_larger==max_larger, set median=min_larger and go to DONE; otherwise set pivot=(min_larger+max_larger)>>1 and go to SEND.
REQ-028 SEND SHALL hold send_req=1 with keep_lower/keep_larger stable, and return to WAIT_FILL in the first cycle fill_done=0.
REQ-029 DONE SHALL hold median_valid=1 with median stable until median_ready=1, then go to IDLE; start in that same cycle SHALL be ignored.
REQ-030 keep_lower and keep_larger SHALL never both be high; both SHALL be 0 outside SEND.
REQ-031 The midpoint pivot SHALL guarantee strict partition shrink per pass, so no iteration limit is required.
REQ-032 Extrema and size inputs SHALL be sampled only in DECIDE.

Reset
REQ-033 On rst=1, in any state including mid-window, the FSM SHALL go to IDLE immediately.
REQ-034 Reset values SHALL be: pivot=INIT_PIVOT, buff_size=0, k=0, median=0, iter_count=0, and all 1-bit outputs 0.
REQ-035 The window in progress at reset SHALL be discarded and SHALL NOT produce median_valid.

Verification
REQ-036 Window {10,20,...,90}, size 9: pass1 lower=9, min=10, max=90 -> send_req, keep_lower, pivot=50; pass2 4/1/4 -> median=50, iter_count=2.
REQ-037 Nine pixels of 77: pass1 lower=9, min=max=77 -> median=77 with no send_req, iter_count=1.
REQ-038 Window {1,2,3,4}, k=1: pass1 -> pivot=2; pass2 lower=1, equal=1, larger=2 -> median=2.
REQ-039 Sizes 3/1/3 with buff_size=9 -> err pulse for 1 cycle, FSM in IDLE, no median_valid.
REQ-040 Hold median_ready=0 for 5 cycles in DONE -> median_valid and median stable; release -> IDLE next cycle.
REQ-041 Assert rst during SEND -> send_req=0 and busy=0 immediately; a new start afterwards runs normally.
